// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: E-stage multiply/divide sequencer with HI/LO registers and issue stall.
// Optional feature macro MD_CANCEL_EN: when defined, cancel aborts an in-flight op and suppresses a coincident start.
module md_unit_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        d_md_use,
   input  logic        cancel,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] res_hi, res_lo;
   logic        can, long_op, sgn, dz;
   logic [31:0] ma, mb, dv, q, r, qs, rsn;
   logic [63:0] sp, up, res_n;
`ifdef MD_CANCEL_EN
   assign can = cancel;
`else
   logic unused_cancel;
   assign unused_cancel = cancel;
   assign can = 1'b0;
`endif
   assign long_op = op <= 3'd4;
   assign stall   = d_md_use & (busy | (start & long_op));
   assign sp = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
   assign up = {32'd0, rs_val} * {32'd0, rt_val};
   // Signed and unsigned divide share one unsigned divider on magnitudes;
   // 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
   assign sgn = op == 3'd2;
   assign dz  = rt_val == 32'd0;
   assign ma  = (sgn & rs_val[31]) ? -rs_val : rs_val;
   assign mb  = (sgn & rt_val[31]) ? -rt_val : rt_val;
   assign dv  = dz ? 32'd1 : mb;
   assign q   = ma / dv;
   assign r   = ma % dv;
   assign qs  = (sgn & (rs_val[31] ^ rt_val[31])) ? -q : q;
   assign rsn = (sgn & rs_val[31]) ? -r : r;
   assign res_n = op == 3'd0 ? sp :
                  op == 3'd1 ? up :
                  op == 3'd4 ? {hi, lo} + sp :
                  dz         ? {rs_val, 32'hFFFF_FFFF} : {rsn, qs};
   // Issue, count down the fixed latency, commit the shadow result to HI/LO.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         busy   <= 1'b0;
         hi     <= 32'd0;
         lo     <= 32'd0;
         res_hi <= 32'd0;
         res_lo <= 32'd0;
      end else if (state == IDLE) begin
         if (start && !can) begin
            if (long_op) begin
               {res_hi, res_lo} <= res_n;
               cnt   <= (op == 3'd2 || op == 3'd3) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
               busy  <= 1'b1;
               state <= RUN;
            end else if (op == 3'd5) hi <= rs_val;
            else if (op == 3'd6) lo <= rs_val;
         end
      end else if (can) begin
         state <= IDLE;
         cnt   <= 4'd0;
         busy  <= 1'b0;
      end else if (cnt == 4'd1) begin
         {hi, lo} <= {res_hi, res_lo};
         state <= IDLE;
         cnt   <= 4'd0;
         busy  <= 1'b0;
      end else cnt <= cnt - 4'd1;
endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
Sequencer for the E-stage multiply/divide resource and the HI/LO register pair in the 5-stage MIPS pipeline. Accepts mult/multu/div/divu/madd/mthi/mtlo from the decoder, models the fixed unit latency with a busy counter, and commits results to HI/LO. Raises a stall request when a D-stage HI/LO-class instruction would collide with an in-flight operation.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu/madd (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  E-stage issue strobe, one cycle per instruction
op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 mthi, 6 mtlo, 7 reserved (ignored)
rs_val  input  32  forwarded rs operand
rt_val  input  32  forwarded rt operand
d_md_use  input  1  D-stage instr is mult/multu/div/divu/madd/mfhi/mflo/mthi/mtlo
cancel  input  1  abort in-flight op (used only with MD_CANCEL_EN)
busy  output  1  long operation in flight
stall  output  1  stall request to hazard unit (combinational)
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset, async on reset_n low: hi=0, lo=0, busy=0, state IDLE, counter=0, result shadows=0. Takes effect mid-operation; the in-flight result is discarded.
- States:
  - IDLE: counter=0.
  - RUN: counter counts down.
- Long op = op 0..4. In IDLE with start and a long op:
  - Latch rs_val/rt_val, compute the 64-bit result into the shadow {res_hi,res_lo}.
  - Load counter = MULT_CYCLES or DIV_CYCLES. Go to RUN.
  - busy=1 from the next cycle.
- RUN:
  - Counter decrements each cycle.
  - On the edge where counter==1: {hi,lo} <= shadow, busy<=0, go to IDLE.
  - busy is high for exactly N cycles. New HI/LO is visible in cycle start+N+1.
- Arithmetic:
  - mult: signed 32x32 -> {hi,lo}.
  - multu: unsigned 32x32 -> {hi,lo}.
  - madd: {hi,lo} + signed product, mod 2^64. Uses HI/LO at the start cycle; HI/LO cannot change while busy.
  - div: lo = signed quotient (truncate toward zero), hi = remainder (sign of dividend). 0x80000000/-1 gives lo=0x80000000, hi=0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (div or divu): hi=rs_val, lo=0xFFFFFFFF.
- mthi/mtlo in IDLE: hi (or lo) <= rs_val at the next edge. No busy, no state change.
- start while busy: ignored entirely (hazard unit guarantees this cannot happen; the bench checks it is harmless). op 7: ignored.
- stall = d_md_use & (busy | (start & long op)). busy drops in the final cycle, so a dependent mfhi in D issues the cycle after busy falls.

Optional Feature:
MD_CANCEL_EN
- Defined: cancel=1 while in RUN forces IDLE, busy=0, counter=0 at the next edge. HI/LO keep their pre-op values. cancel coincident with start in IDLE suppresses the start, including mthi/mtlo.
- cancel coinciding with the commit edge: the cancel wins and there is no commit.
- Undefined: cancel is ignored; every issued op commits.

Test Plan:
- mult rs=0xFFFFFFFE, rt=3, MULT_CYCLES=5 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- divu rs=100, rt=7 -> busy high 10 cycles, then lo=14, hi=2. div rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div rs=5, rt=0 -> hi=5, lo=0xFFFFFFFF.
- mthi 0x1, mtlo 0xFFFFFFFF, then madd rs=1, rt=1 -> hi=0x2, lo=0x0. Also check start asserted during busy leaves the result unchanged.
- Hazard: d_md_use=1 (mflo) during the start cycle and every busy cycle -> stall=1 on each; stall=0 the cycle after busy falls, with lo already updated.
- Reset: drop reset_n at busy cycle 3 of a div -> busy=0, hi=lo=0 immediately without a clock edge; the next mult behaves normally.
- MD_CANCEL_EN: cancel at busy cycle 2 of a mult with hi=0xA, lo=0xB -> busy=0 next cycle, hi=0xA and lo=0xB held. Without the macro, the same stimulus commits normally.
